// File: rtl/aes_pkg.sv
// Shared AES definitions: round-key/word types, round count, Rcon table and
// key-expansion FSM states.
package aes_pkg;

  typedef logic [127:0] round_key_t;
  typedef logic [31:0]  word_t;

  localparam int unsigned NUM_ROUNDS = 10;

  // Indexed directly by the 4-bit round counter; entries 0 and 11..15 are unused.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_e;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (8-bit in, 8-bit out).
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock after key_load, 11 slots held.
// Optional build macro AES_KEYEXP_READ_GATE_EN zeroes both key outputs while keys_ready is low.
module aes_key_expansion (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic [3:0]   round_key_addr,
  output logic [127:0] round_key_0,
  output logic [127:0] round_key_output,
  output logic         keys_ready,
  output logic         busy
);
  import aes_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  round_key_t slot_q [0:NUM_ROUNDS];

  logic       slot_we;
  logic [3:0] slot_wa;
  round_key_t slot_wd;

  round_key_t prev_key, step_key, rd_key;
  word_t      p0, p1, p2, p3;
  word_t      rot_w, sub_w, t_w;
  word_t      n0, n1, n2, n3;

  // Previous slot selected by counter-1 without an out-of-range dynamic index.
  always_comb begin
    prev_key = '0;
    for (int unsigned k = 0; k < NUM_ROUNDS; k++) begin
      if (cnt_q == 4'(k + 1)) prev_key = slot_q[k];
    end
  end

  assign {p0, p1, p2, p3} = prev_key;
  assign rot_w = {p3[23:0], p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_w[8*g +: 8]),
      .data_o (sub_w[8*g +: 8])
    );
  end

  assign t_w      = sub_w ^ {RCON[cnt_q], 24'h0};
  assign n0       = p0 ^ t_w;
  assign n1       = p1 ^ n0;
  assign n2       = p2 ^ n1;
  assign n3       = p3 ^ n2;
  assign step_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_we = 1'b0;
    slot_wa = '0;
    slot_wd = '0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (key_load) begin
          slot_we = 1'b1;
          slot_wd = cipher_key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (key_load) begin
          slot_we = 1'b1;
          slot_wd = cipher_key;
          cnt_d   = 4'd1;
        end else begin
          slot_we = 1'b1;
          slot_wa = cnt_q;
          slot_wd = step_key;
          if (cnt_q == 4'(NUM_ROUNDS)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // keys_ready trails entry to READY by one cycle and drops on the load edge.
    ready_d = (state_q == READY) && !key_load;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int unsigned k = 0; k <= NUM_ROUNDS; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      for (int unsigned k = 0; k <= NUM_ROUNDS; k++) begin
        if (slot_we && (slot_wa == 4'(k))) slot_q[k] <= slot_wd;
      end
    end
  end

  always_comb begin
    rd_key = '0;
    for (int unsigned k = 0; k <= NUM_ROUNDS; k++) begin
      if (round_key_addr == 4'(k)) rd_key = slot_q[k];
    end
  end

  assign keys_ready = ready_q;

`ifdef AES_KEYEXP_READ_GATE_EN
  assign round_key_0      = ready_q ? slot_q[0] : '0;
  assign round_key_output = ready_q ? rd_key    : '0;
`else
  assign round_key_0      = slot_q[0];
  assign round_key_output = rd_key;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion; reference schedule built from GF(2^8) arithmetic.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         key_load;
  logic [127:0] cipher_key;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key_0;
  logic [127:0] round_key_output;
  logic         keys_ready;
  logic         busy;

  aes_key_expansion dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .key_load         (key_load),
    .cipher_key       (cipher_key),
    .round_key_addr   (round_key_addr),
    .round_key_0      (round_key_0),
    .round_key_output (round_key_output),
    .keys_ready       (keys_ready),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   sb  [0:255];
  logic [127:0] mdl [0:10];
  vec_t         tbl [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] vis(input logic [127:0] v, input bit rdy);
`ifdef AES_KEYEXP_READ_GATE_EN
    return rdy ? v : '0;
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  task automatic expand_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) mdl[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [127:0] key);
    chk($sformatf("%s rk0", tag), round_key_0, vis(key, 1'b1));
    for (int k = 0; k < 16; k++) begin
      round_key_addr = 4'(k);
      #1;
      chk($sformatf("%s slot%0d", tag, k), round_key_output, (k <= 10) ? vis(mdl[k], 1'b1) : '0);
    end
  endtask

  // One-cycle load, then bounded wait for keys_ready with latency and busy-width checks.
  task automatic run_load(input logic [127:0] key, input string tag);
    int edges, bcnt;
    expand_model(key);
    key_load   = 1'b1;
    cipher_key = key;
    tick();
    key_load   = 1'b0;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    chk($sformatf("%s ready_drop", tag), keys_ready, 0);
    chk($sformatf("%s busy_start", tag), busy, 1);
    edges = 0;
    bcnt  = 0;
    while (!keys_ready && edges < 40) begin
      if (busy) bcnt++;
      tick();
      edges++;
    end
    chk($sformatf("%s ready_latency", tag), edges, 11);
    chk($sformatf("%s busy_cycles", tag), bcnt, 10);
    check_all(tag, key);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [127:0] ka, kb;
    int bcnt;
    build_sbox();
    key_load = 1'b0; cipher_key = '0; round_key_addr = '0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    chk("rst ready", keys_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst rk0", round_key_0, '0);
    for (int a = 0; a < 16; a++) begin
      round_key_addr = 4'(a);
      #1;
      chk($sformatf("rst addr%0d", a), round_key_output, '0);
    end
    tick(); tick();
    n_rst = 1'b1;
    tick();
    chk("idle ready", keys_ready, 0);

    // FIPS key, slot r visible after edge r
    expand_model(FIPS_KEY);
    key_load = 1'b1; cipher_key = FIPS_KEY;
    tick();
    key_load = 1'b0; cipher_key = {$urandom, $urandom, $urandom, $urandom};
    chk("fips busy0", busy, 1);
    chk("fips rk0 early", round_key_0, vis(FIPS_KEY, 1'b0));
    bcnt = 0;
    for (int r = 1; r <= 10; r++) begin
      if (busy) bcnt++;
      round_key_addr = 4'(r);
      tick();
      chk($sformatf("fips edge%0d slot", r), round_key_output, vis(mdl[r], 1'b0));
      chk($sformatf("fips edge%0d ready", r), keys_ready, 0);
    end
    if (busy) bcnt++;
    chk("fips busy after edge10", busy, 0);
    tick();
    chk("fips ready edge11", keys_ready, 1);
    chk("fips busy width", bcnt, 10);

    tbl.delete();
    for (int k = 0; k < 16; k++) begin
      vec_t v;
      v.addr = 4'(k);
      v.exp  = (k == 1) ? FIPS_R1 : (k == 10) ? FIPS_R10 : (k <= 10) ? mdl[k] : '0;
      tbl.push_back(v);
    end
    chk("fips rk0", round_key_0, vis(FIPS_KEY, 1'b1));
    for (int i = 0; i < tbl.size(); i++) begin
      round_key_addr = tbl[i].addr;
      #1;
      chk($sformatf("fips tbl addr%0d", tbl[i].addr), round_key_output, vis(tbl[i].exp, 1'b1));
    end

    // key_load low: cipher_key changes are ignored
    for (int i = 0; i < 3; i++) begin
      cipher_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk($sformatf("ignore%0d rk0", i), round_key_0, vis(FIPS_KEY, 1'b1));
      chk($sformatf("ignore%0d ready", i), keys_ready, 1);
    end

    run_load('0, "zero");
    round_key_addr = 4'd1;
    #1;
    chk("zero addr1 vector", round_key_output, vis(ZERO_R1, 1'b1));

    for (int n = 0; n < 4; n++)
      run_load({$urandom, $urandom, $urandom, $urandom}, $sformatf("rand%0d", n));

    // restart 4 cycles into expansion of key A
    ka = {$urandom, $urandom, $urandom, $urandom};
    expand_model(ka);
    key_load = 1'b1; cipher_key = ka;
    tick();
    key_load = 1'b0;
    tick(); tick();
    round_key_addr = 4'd3;
    tick();
    chk("restart partial slot3", round_key_output, vis(mdl[3], 1'b0));
    chk("restart busy", busy, 1);
    run_load(FIPS_KEY, "restart");

    // held key_load keeps restarting
    kb = {$urandom, $urandom, $urandom, $urandom};
    key_load = 1'b1; cipher_key = kb;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d busy", i), busy, 1);
      chk($sformatf("hold%0d ready", i), keys_ready, 0);
      chk($sformatf("hold%0d rk0", i), round_key_0, vis(kb, 1'b0));
    end
    run_load({$urandom, $urandom, $urandom, $urandom}, "hold");

    // asynchronous reset in the middle of expansion
    key_load = 1'b1; cipher_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    key_load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_rst = 1'b0;
    #1;
    chk("midrst ready", keys_ready, 0);
    chk("midrst busy", busy, 0);
    chk("midrst rk0", round_key_0, '0);
    for (int k = 0; k < 11; k++) begin
      round_key_addr = 4'(k);
      #1;
      chk($sformatf("midrst slot%0d", k), round_key_output, '0);
    end
    tick();
    n_rst = 1'b1;
    tick();
    chk("postrst idle busy", busy, 0);
    run_load(FIPS_KEY, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
